// File: rtl/alu_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader_pkg
// Description : Shared state encodings, button indices and widths for the
//               ALU operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_loader_pkg;

    localparam int c_OPERAND_W = 8;
    localparam int c_OPCODE_W  = 3;
    localparam int c_NUM_BTN   = 4;
    localparam int c_DEB_CNT_W = 20;

    localparam int c_BTN_LOAD_A = 0;
    localparam int c_BTN_LOAD_B = 1;
    localparam int c_BTN_EXEC   = 2;
    localparam int c_BTN_CLEAR  = 3;

    localparam logic [1:0] c_ST_IDLE      = 2'b00;
    localparam logic [1:0] c_ST_A_LOADED  = 2'b01;
    localparam logic [1:0] c_ST_AB_LOADED = 2'b10;
    localparam logic [1:0] c_ST_RESULT    = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_operand_loader_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser, restartable debounce counter and
//               rising-edge detector producing a one-cycle press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import alu_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [c_DEB_CNT_W-1:0] c_CNT_LAST = c_DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    logic [c_DEB_CNT_W-1:0] r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_press;
    logic [1:0]             r_warm;
    logic                   r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_warm    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_warm    <= {r_warm[0], 1'b1};
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Arm only once the synchroniser carries the real pin and shows it released,
            // so a button held across reset cannot fire until pressed again.
            if (r_warm[1] && !r_sync2 && !r_level) begin
                r_armed <= 1'b1;
            end
            r_press <= r_level & ~r_level_d & r_armed;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader
// Description : Debounced button commands drive a load/execute FSM that
//               captures ALU operands and opcode from the switches.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] sw,
    input  logic [3:0]  btn,
    output logic [7:0]  operand_a,
    output logic [7:0]  operand_b,
    output logic [2:0]  opcode,
    output logic        valid,
    output logic [1:0]  state_led
);

    logic [c_NUM_BTN-1:0]   w_btn_level_unused;
    logic [c_NUM_BTN-1:0]   w_press;

    logic [1:0]             r_state;
    logic [c_OPERAND_W-1:0] r_operand_a;
    logic [c_OPERAND_W-1:0] r_operand_b;
    logic [c_OPCODE_W-1:0]  r_opcode;
    logic                   r_valid;

    logic [1:0]             w_state_nxt;
    logic [c_OPERAND_W-1:0] w_operand_a_nxt;
    logic [c_OPERAND_W-1:0] w_operand_b_nxt;
    logic [c_OPCODE_W-1:0]  w_opcode_nxt;
    logic                   w_valid_nxt;

    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk    (clk),
                .rst    (rst),
                .btn_raw(btn[gi]),
                .level  (w_btn_level_unused[gi]),
                .press  (w_press[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_operand_a <= w_operand_a_nxt;
            r_operand_b <= w_operand_b_nxt;
            r_opcode    <= w_opcode_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // Only the highest-priority press of the cycle is acted on.
    always_comb begin
        w_state_nxt     = r_state;
        w_operand_a_nxt = r_operand_a;
        w_operand_b_nxt = r_operand_b;
        w_opcode_nxt    = r_opcode;
        w_valid_nxt     = 1'b0;
        if (w_press[c_BTN_CLEAR]) begin
            w_state_nxt     = c_ST_IDLE;
            w_operand_a_nxt = '0;
            w_operand_b_nxt = '0;
            w_opcode_nxt    = '0;
        end else if (w_press[c_BTN_LOAD_A]) begin
            w_operand_a_nxt = sw[c_OPERAND_W-1:0];
            case (r_state)
                c_ST_IDLE:   w_state_nxt = c_ST_A_LOADED;
                c_ST_RESULT: w_state_nxt = c_ST_AB_LOADED;
                default:     w_state_nxt = r_state;
            endcase
        end else if (w_press[c_BTN_LOAD_B]) begin
            if (r_state != c_ST_IDLE) begin
                w_operand_b_nxt = sw[c_OPERAND_W-1:0];
                w_state_nxt     = c_ST_AB_LOADED;
            end
        end else if (w_press[c_BTN_EXEC]) begin
            if (r_state == c_ST_AB_LOADED || r_state == c_ST_RESULT) begin
                w_opcode_nxt = sw[c_OPERAND_W +: c_OPCODE_W];
                w_valid_nxt  = 1'b1;
                w_state_nxt  = c_ST_RESULT;
            end
        end
    end

    assign operand_a = r_operand_a;
    assign operand_b = r_operand_b;
    assign opcode    = r_opcode;
    assign valid     = r_valid;
    assign state_led = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Scoreboard bench; a command model queues expected output
//               updates with their arrival cycle, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int c_N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] sw;
    logic [3:0]  btn;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [2:0]  opcode;
    logic        valid;
    logic [1:0]  state_led;

    alu_operand_loader #(.DEBOUNCE_CYCLES(c_N)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn      (btn),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .opcode   (opcode),
        .valid    (valid),
        .state_led(state_led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [1:0] st;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    logic [7:0] m_a  = '0;
    logic [7:0] m_b  = '0;
    logic [2:0] m_op = '0;
    logic [1:0] m_st = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one command cycle to the model; queue the update if it is visible.
    task automatic apply_model(input logic [3:0] mask);
        exp_t e;
        logic v;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [2:0] op0;
        logic [1:0] st0;
        a0 = m_a; b0 = m_b; op0 = m_op; st0 = m_st; v = 1'b0;
        if (mask[3]) begin
            m_a = '0; m_b = '0; m_op = '0; m_st = 2'b00;
        end else if (mask[0]) begin
            m_a = sw[7:0];
            if (m_st == 2'b00) m_st = 2'b01;
            else if (m_st == 2'b11) m_st = 2'b10;
        end else if (mask[1]) begin
            if (m_st != 2'b00) begin
                m_b = sw[7:0];
                m_st = 2'b10;
            end
        end else if (mask[2]) begin
            if (m_st == 2'b10 || m_st == 2'b11) begin
                m_op = sw[10:8];
                v = 1'b1;
                m_st = 2'b11;
            end
        end
        if (v || m_a != a0 || m_b != b0 || m_op != op0 || m_st != st0) begin
            e.t = cyc + c_N + 4;
            e.a = m_a; e.b = m_b; e.op = m_op; e.st = m_st; e.v = v;
            q.push_back(e);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(posedge clk); #1;
        btn = btn | mask;
        apply_model(mask);
        repeat (hold) @(posedge clk);
        #1;
        btn = btn & ~mask;
        repeat (2 * c_N + 10) @(posedge clk);
        #1;
    endtask

    logic [7:0] p_a  = '0;
    logic [7:0] p_b  = '0;
    logic [2:0] p_op = '0;
    logic [1:0] p_st = '0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && ({operand_a, operand_b, opcode, state_led} != {p_a, p_b, p_op, p_st} || valid)) begin
            if (q.size() == 0) begin
                check_eq("spurious_update", {10'd0, valid, state_led, opcode, operand_b, operand_a},
                         {10'd0, 1'b0, p_st, p_op, p_b, p_a});
            end else begin
                e = q.pop_front();
                check_eq("evt_cycle", cyc, e.t);
                check_eq("operand_a", operand_a, e.a);
                check_eq("operand_b", operand_b, e.b);
                check_eq("opcode", opcode, e.op);
                check_eq("state_led", state_led, e.st);
                check_eq("valid", valid, e.v);
            end
        end
        if (mon_en && q.size() > 0 && cyc > q[0].t) begin
            check_eq("evt_timeout", cyc, q[0].t);
            void'(q.pop_front());
        end
        p_a = operand_a; p_b = operand_b; p_op = opcode; p_st = state_led;
    end

    initial begin
        int t_exec;
        rst = 1'b1;
        btn = '0;
        sw  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_operand_a", operand_a, 8'h00);
        check_eq("rst_operand_b", operand_b, 8'h00);
        check_eq("rst_opcode", opcode, 3'd0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_state_led", state_led, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Illegal order from IDLE
        sw = 11'h455;
        press(4'b0010, c_N + 4);
        press(4'b0100, c_N + 4);
        check_eq("illegal_operand_b", operand_b, 8'h00);
        check_eq("illegal_state_led", state_led, 2'b00);

        // Normal flow
        sw = 11'h03C;
        press(4'b0001, c_N + 4);
        sw = 11'h005;
        press(4'b0010, c_N + 4);
        sw = {3'd3, 8'h05};
        press(4'b0100, c_N + 4);

        // Hold execute, then re-press with new opcode
        sw = 11'h022;
        press(4'b0010, c_N + 4);
        sw = {3'd5, 8'h22};
        press(4'b0100, 50);
        sw = {3'd6, 8'h22};
        press(4'b0100, c_N + 4);

        // Bounce on load A, accepted only from the final stable edge
        sw = 11'h081;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            btn[0] = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        btn[0] = 1'b1;
        apply_model(4'b0001);
        repeat (c_N + 8) @(posedge clk);
        #1;
        btn[0] = 1'b0;
        repeat (2 * c_N + 10) @(posedge clk);
        #1;

        // Glitch shorter than the debounce window
        sw = 11'h099;
        btn[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn[0] = 1'b0;
        repeat (2 * c_N + 10) @(posedge clk);
        #1;
        check_eq("glitch_operand_a", operand_a, m_a);

        // Simultaneous presses
        sw = 11'h7FF;
        press(4'b1001, c_N + 4);
        press(4'b0011, c_N + 4);

        // Reset asserted while valid is high, with load A held across reset
        sw = 11'h011;
        press(4'b0010, c_N + 4);
        sw = {3'd2, 8'h11};
        @(posedge clk); #1;
        btn[2] = 1'b1;
        apply_model(4'b0100);
        t_exec = cyc + c_N + 4;
        while (cyc < t_exec && cyc < t_exec + 20) @(negedge clk);
        #1;
        check_eq("pre_rst_valid", valid, 1'b1);
        mon_en = 1'b0;
        btn = 4'b0001;
        rst = 1'b1;
        #1;
        check_eq("arst_operand_a", operand_a, 8'h00);
        check_eq("arst_operand_b", operand_b, 8'h00);
        check_eq("arst_opcode", opcode, 3'd0);
        check_eq("arst_valid", valid, 1'b0);
        check_eq("arst_state_led", state_led, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_a = '0; m_b = '0; m_op = '0; m_st = 2'b00;
        mon_en = 1'b1;
        repeat (3 * c_N + 10) @(posedge clk);
        #1;
        check_eq("held_state_led", state_led, 2'b00);
        check_eq("held_operand_a", operand_a, 8'h00);
        btn[0] = 1'b0;
        repeat (2 * c_N + 10) @(posedge clk);
        sw = 11'h042;
        press(4'b0001, c_N + 4);

        check_eq("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
